mips_div_unit: RTL and testbench

- Iterative 32-bit divider in the EX stage, directly downstream of the main decoder.
- Consumes DIV/DIVU instructions that the decoder marks with hilowrite.
- Produces {remainder, quotient} for the HI/LO register write, and holds the pipeline stalled while it iterates.
- Radix-2 restoring algorithm: one quotient bit per clock, plus a fast path for divide-by-zero.

---
 rtl/mips_div_unit_pkg.sv | 18 +
 rtl/mips_div_step.sv | 15 +
 rtl/mips_div_unit.sv | 118 +++++++++++
 tb/tb_mips_div_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mips_div_unit_pkg.sv
// mips_div_unit_pkg: shared state encodings, control constants and decoder funct codes for the divider
package mips_div_unit_pkg;
   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic [5:0] EXE_DIV  = 6'b011010;
   localparam logic [5:0] EXE_DIVU = 6'b011011;
   function automatic logic is_div_funct(input logic [5:0] funct);
      return (funct == EXE_DIV) || (funct == EXE_DIVU);
   endfunction
endpackage

// File: rtl/mips_div_step.sv
// mips_div_step: one restoring-division step, shift in a dividend bit then conditionally subtract the divisor
module mips_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   part_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             bit_i,
   output logic [WIDTH:0]   part_o,
   output logic             q_o
);
   logic [WIDTH+1:0] diff;
   assign diff   = {part_i, bit_i} - {2'b00, divisor_i};
   assign q_o    = ~diff[WIDTH+1];
   assign part_o = q_o ? diff[WIDTH:0] : {part_i[WIDTH-1:0], bit_i};
endmodule

// File: rtl/mips_div_unit.sv
// mips_div_unit: iterative radix-2 DIV/DIVU unit producing {remainder, quotient} and stalling the pipeline while busy
module mips_div_unit
   import mips_div_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic               signed_div,
   input  logic [WIDTH-1:0]   opdata1,
   input  logic [WIDTH-1:0]   opdata2,
   input  logic               annul,
   output logic [2*WIDTH-1:0] result,
   output logic               ready,
   output logic               stall
);
   div_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [WIDTH:0]     part_q, part_d;
   logic               s1_q, s1_d;
   logic               s2_q, s2_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic [WIDTH:0]     step_part;
   logic               step_q;
   logic               neg1, neg2;
   logic [WIDTH-1:0]   abs1, abs2, quot_nxt, quot_fix, rem_fix;

   mips_div_step #(.WIDTH(WIDTH)) u_step (
      .part_i    (part_q),
      .divisor_i (dvs_q),
      .bit_i     (dvd_q[WIDTH-1]),
      .part_o    (step_part),
      .q_o       (step_q)
   );

   assign neg1     = signed_div & opdata1[WIDTH-1];
   assign neg2     = signed_div & opdata2[WIDTH-1];
   assign abs1     = neg1 ? -opdata1 : opdata1;
   assign abs2     = neg2 ? -opdata2 : opdata2;
   assign quot_nxt = {dvd_q[WIDTH-2:0], step_q};
   assign quot_fix = (s1_q ^ s2_q) ? -quot_nxt : quot_nxt;
   assign rem_fix  = s1_q ? -step_part[WIDTH-1:0] : step_part[WIDTH-1:0];

   assign result = result_q;
   assign ready  = (state_q == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
   assign stall  = ((state_q == DIV_FREE && start == DIV_START) || state_q == DIV_BYZERO || state_q == DIV_ON)
                   ? DIV_START : DIV_STOP;

   // next-state: latch operands in idle, iterate one quotient bit per cycle, apply sign fix-up on the last step
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      part_d   = part_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      result_d = result_q;
      case (state_q)
         DIV_FREE: begin
            if (start == DIV_START && !annul) begin
               state_d = (opdata2 == '0) ? DIV_BYZERO : DIV_ON;
               cnt_d   = '0;
               dvd_d   = abs1;
               dvs_d   = abs2;
               part_d  = '0;
               s1_d    = neg1;
               s2_d    = neg2;
            end
         end
         DIV_BYZERO: begin
            state_d  = annul ? DIV_FREE : DIV_END;
            result_d = annul ? result_q : '0;
         end
         DIV_ON: begin
            if (annul) begin
               state_d = DIV_FREE;
            end else begin
               part_d = step_part;
               dvd_d  = quot_nxt;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH-1)) begin
                  state_d  = DIV_END;
                  result_d = {rem_fix, quot_fix};
               end
            end
         end
         default: state_d = DIV_FREE;
      endcase
   end

   // state and datapath registers, cleared asynchronously by resetn
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= DIV_FREE;
         cnt_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         part_q   <= '0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         part_q   <= part_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         result_q <= result_d;
      end
   end
endmodule

// File: tb/tb_mips_div_unit.sv
// tb_mips_div_unit: table, directed and random checks of mips_div_unit against an arithmetic reference model
module tb_mips_div_unit;
   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic        signed_div;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic        annul;
   logic [63:0] result;
   logic        ready;
   logic        stall;

   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] last_exp = '0;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      string       nm;
   } vec_t;

   vec_t tbl[11];

   mips_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .signed_div (signed_div),
      .opdata1    (opdata1),
      .opdata2    (opdata2),
      .annul      (annul),
      .result     (result),
      .ready      (ready),
      .stall      (stall)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 0) return 64'd0;
      if (!sgn) return {a % b, a / b};
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit noise, input string nm);
      int lat = 0;
      int exp_lat;
      int bad_stall = 0;
      bit got = 0;
      exp_lat = (b == 0) ? 2 : 33;
      @(posedge clk); #1;
      start = 1; signed_div = sgn; opdata1 = a; opdata2 = b;
      @(negedge clk);
      if (stall !== 1'b1) bad_stall++;
      for (int c = 1; c <= 60 && !got; c++) begin
         @(posedge clk); #1;
         if (noise) begin
            start = 1'($urandom_range(0, 1)); signed_div = 1'($urandom_range(0, 1));
            opdata1 = $urandom; opdata2 = $urandom;
         end else start = 0;
         @(negedge clk);
         if (ready === 1'b1) begin
            got = 1; lat = c; start = 0;
            check({nm, "_result"}, result, exp);
            if (stall !== 1'b0) bad_stall++;
         end else if (stall !== 1'b1) bad_stall++;
      end
      check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
      check({nm, "_stall"}, 64'(bad_stall), 64'd0);
      if (got) begin
         @(posedge clk); #1; start = 0;
         @(negedge clk);
         check({nm, "_ready_fall"}, 64'(ready), 64'd0);
         last_exp = exp;
      end
   endtask

   initial begin
      int ready_seen;
      int stall_seen;
      logic        sgn;
      logic [31:0] a, b;
      tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'h00000002, 32'h0000000E, "divu_100_7"};
      tbl[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"};
      tbl[2]  = '{1'b1, 32'h00000007,   32'hFFFFFFFE,   32'h00000001, 32'hFFFFFFFD, "div_7_m2"};
      tbl[3]  = '{1'b0, 32'h12345678,   32'h00000000,   32'h00000000, 32'h00000000, "divu_by_zero"};
      tbl[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32'h80000000, "div_overflow"};
      tbl[5]  = '{1'b0, 32'hFFFFFFFF,   32'h00000001,   32'h00000000, 32'hFFFFFFFF, "divu_max_1"};
      tbl[6]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE, 32'h0000000E, "div_m100_m7"};
      tbl[7]  = '{1'b1, 32'h00000005,   32'h00000000,   32'h00000000, 32'h00000000, "div_by_zero"};
      tbl[8]  = '{1'b1, 32'h80000000,   32'h00000001,   32'h00000000, 32'h80000000, "div_min_1"};
      tbl[9]  = '{1'b0, 32'h00000000,   32'h00000005,   32'h00000000, 32'h00000000, "divu_0_5"};
      tbl[10] = '{1'b0, 32'hFFFFFFFF,   32'h80000000,   32'h7FFFFFFF, 32'h00000001, "divu_max_half"};

      resetn = 0; start = 0; signed_div = 0; opdata1 = '0; opdata2 = '0; annul = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_result", result, 64'd0);
      check("reset_ready", 64'(ready), 64'd0);
      check("reset_stall", 64'(stall), 64'd0);
      @(posedge clk); #1; resetn = 1;

      foreach (tbl[i])
         run_div(tbl[i].sgn, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo}, (i % 2) == 1, tbl[i].nm);

      // annul at cycle 10 of a DIVU: no ready, result unchanged, then a clean 9/3
      @(posedge clk); #1;
      start = 1; signed_div = 0; opdata1 = 32'd1000; opdata2 = 32'd3;
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk); #1; start = 0;
      end
      @(posedge clk); #1; annul = 1;
      @(negedge clk);
      check("annul_c10_stall", 64'(stall), 64'd1);
      @(posedge clk); #1; annul = 0;
      @(negedge clk);
      check("annul_c11_stall", 64'(stall), 64'd0);
      check("annul_c11_ready", 64'(ready), 64'd0);
      check("annul_result_kept", result, last_exp);
      ready_seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ready === 1'b1) ready_seen++;
      end
      check("annul_no_ready", 64'(ready_seen), 64'd0);
      run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, "divu_9_3_after_annul");

      // annul together with start in idle keeps the unit idle
      @(posedge clk); #1;
      start = 1; annul = 1; signed_div = 0; opdata1 = 32'd50; opdata2 = 32'd5;
      @(posedge clk); #1; start = 0; annul = 0;
      ready_seen = 0; stall_seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ready === 1'b1) ready_seen++;
         if (stall === 1'b1) stall_seen++;
      end
      check("idle_annul_no_ready", 64'(ready_seen), 64'd0);
      check("idle_annul_no_stall", 64'(stall_seen), 64'd0);
      check("idle_annul_result", result, last_exp);

      // asynchronous reset at cycle 15 of a division
      @(posedge clk); #1;
      start = 1; signed_div = 0; opdata1 = 32'hDEADBEEF; opdata2 = 32'd13;
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk); #1; start = 0;
      end
      #2 resetn = 0;
      #1;
      check("async_rst_result", result, 64'd0);
      check("async_rst_ready", 64'(ready), 64'd0);
      check("async_rst_stall", 64'(stall), 64'd0);
      @(posedge clk); #1; resetn = 1;
      run_div(1'b0, 32'hDEADBEEF, 32'd13, model(1'b0, 32'hDEADBEEF, 32'd13), 1'b1, "after_reset");

      for (int i = 0; i < 40; i++) begin
         sgn = 1'($urandom_range(0, 1));
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = $urandom;
            1: b = $urandom_range(1, 15);
            2: b = (i % 4 == 0) ? 32'd0 : ~$urandom_range(0, 15);
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         run_div(sgn, a, b, model(sgn, a, b), $urandom_range(0, 1) == 1, $sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
